fetch_issue: RTL

Instruction-fetch front end that drives the IF/ID pipeline latch. Holds the fetch PC, issues one-outstanding-request reads to instruction memory, and buffers returned words in a small FIFO. Presents `{instruction, PC, PC+4}` to the downstream latch, honouring its `STALL` and `FLUSH`. On a flush it redirects to a new target and discards any in-flight response.

---
 rtl/fetch_issue.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_issue.sv
// Instruction fetch front end: one outstanding imem read feeding a DEPTH-entry FIFO toward the IF/ID latch (optional FETCH_ALIGN_CHECK_EN).
// Latency: first word visible 1 cycle after a zero-wait ACK; flush discards any in-flight response.
// Backpressure: STALL holds the head; requests continue until the FIFO is full, and REQ is never combinational on STALL.
module fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic [31:0] REDIRECT_PC,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic        INSTR_VALID
`ifdef FETCH_ALIGN_CHECK_EN
   ,output logic        ALIGN_ERR
`endif
);

    localparam int              PW       = (DEPTH > 2) ? 2 : 1;
    localparam int              CW       = (DEPTH > 3) ? 3 : 2;
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
`ifdef FETCH_ALIGN_CHECK_EN
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
`else
        S_DISCARD = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     stale_addr_q, stale_addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [31:0]     pc_d    [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
    logic            align_err_q, align_err_d;
`endif

    logic            req;
    logic            ack;
    logic            push;
    logic            pop;
    logic            clear;
    logic            flush_take;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        req = 1'b0;
        case (state_q)
            S_FETCH:           req = (count_q < FULL_CNT);
            S_WAIT, S_DISCARD: req = 1'b1;
            default:           req = 1'b0;
        endcase
        ack          = req & IMEM_ACK;
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;
        push         = 1'b0;
        clear        = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        align_err_d  = align_err_q;
        flush_take   = FLUSH & ~align_err_q;
`else
        flush_take   = FLUSH;
`endif

        case (state_q)
            S_FETCH: begin
                if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (req) begin
                    stale_addr_d = fetch_pc_q;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_FETCH;
                end
            end
            S_DISCARD: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (ack) state_d = align_err_q ? S_HALT : S_FETCH;
`else
                if (ack) state_d = S_FETCH;
`endif
            end
            default: ;
        endcase

        // A flush owns the cycle: any ACK now is dropped, and a still-pending read must be drained in DISCARD.
        if (flush_take) begin
            clear      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = REDIRECT_PC;
            state_d    = (req && !ack) ? S_DISCARD : S_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
            if (REDIRECT_PC[1:0] != 2'b00) begin
                align_err_d = 1'b1;
                if (!(req && !ack)) state_d = S_HALT;
            end
`endif
        end
    end

    assign pop = (count_q != '0) & ~STALL & ~FLUSH;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = IMEM_DATA;
                pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d          = next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            stale_addr_q <= stale_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q  <= align_err_d;
`endif
        end
    end

    // Reset forces REQ low immediately, not only after the state register clears.
    assign IMEM_REQ          = req & ~RESET;
    assign IMEM_ADDR         = IMEM_REQ ? ((state_q == S_FETCH) ? fetch_pc_q : stale_addr_q) : '0;
    assign INSTR_VALID       = (count_q != '0);
    assign Instr1_IF         = INSTR_VALID ? instr_q[rd_ptr_q] : '0;
    assign Instr_PC_IF       = INSTR_VALID ? pc_q[rd_ptr_q] : '0;
    assign Instr_PC_Plus4_IF = INSTR_VALID ? (pc_q[rd_ptr_q] + 32'd4) : '0;
`ifdef FETCH_ALIGN_CHECK_EN
    assign ALIGN_ERR         = align_err_q;
`endif

endmodule
